// File: rtl/ssd_pkg.sv
// Shared encodings for the seven-segment BCD display path: converter states,
// active-low segment codes {a..g} and active-low anode patterns.
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [3:0] AN_THOU = 4'b0111;
    localparam logic [3:0] AN_HUND = 4'b1011;
    localparam logic [3:0] AN_TENS = 4'b1101;
    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    function automatic logic [15:0] dd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Free-running: re-samples bin every DATA_W+2 cycles and presents whole results only.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | capture bin, clear accumulator, load iteration down-counter
//   SHIFT | one adjust+shift iteration per cycle until counter hits 0
//   LATCH | publish accumulator to bcd, pulse valid
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int DATA_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bin,
    output logic [15:0]       bcd,
    output logic              valid
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(DATA_W - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [15:0]       r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [15:0]       r_bcd;
    logic              r_valid;

    logic [15:0] w_adj;
    logic [15:0] w_acc_next;

    assign w_adj      = dd_adjust(r_acc);
    assign w_acc_next = {w_adj[14:0], r_shift[DATA_W-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_shift <= bin;
                    r_acc   <= '0;
                    r_cnt   <= ITER_LAST;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) r_state <= LATCH;
                end
                LATCH: begin
                    r_bcd   <= r_acc;
                    r_valid <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bcd   = r_bcd;
    assign valid = r_valid;

endmodule

// File: rtl/ssd_bcd_driver.sv
// Four-digit common-anode seven-segment driver: converts a binary value to BCD
// and time-multiplexes the digits with registered active-low anode/segment outputs.
module ssd_bcd_driver
    import ssd_pkg::*;
#(
    parameter int DATA_W       = 13,
    parameter int REFRESH_BITS = 18,
    parameter int BLANK_LZ     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value,
    output logic              bcd_valid,
    output logic [3:0]        Anode,
    output logic [6:0]        Seven_Seg_Out
);

    logic [REFRESH_BITS-1:0] r_refresh;
    logic [3:0]              r_anode;
    logic [6:0]              r_seg;

    logic [15:0] w_bcd;
    logic        w_valid;
    logic [1:0]  w_sel;
    logic [3:0]  w_digit;
    logic [3:0]  w_anode;
    logic        w_blank;
    logic [6:0]  w_seg;
    logic        w_thou_z;
    logic        w_hund_z;
    logic        w_tens_z;

    bin2bcd_seq #(
        .DATA_W (DATA_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .bin   (value),
        .bcd   (w_bcd),
        .valid (w_valid)
    );

    assign w_sel    = r_refresh[REFRESH_BITS-1 -: 2];
    assign w_thou_z = (w_bcd[15:12] == 4'd0);
    assign w_hund_z = (w_bcd[11:8]  == 4'd0);
    assign w_tens_z = (w_bcd[7:4]   == 4'd0);

    always_comb begin
        w_digit = w_bcd[3:0];
        w_anode = AN_ONES;
        w_blank = 1'b0;
        case (w_sel)
            2'd0: begin
                w_digit = w_bcd[15:12];
                w_anode = AN_THOU;
                w_blank = w_thou_z;
            end
            2'd1: begin
                w_digit = w_bcd[11:8];
                w_anode = AN_HUND;
                w_blank = w_thou_z & w_hund_z;
            end
            2'd2: begin
                w_digit = w_bcd[7:4];
                w_anode = AN_TENS;
                w_blank = w_thou_z & w_hund_z & w_tens_z;
            end
            default: begin
                w_digit = w_bcd[3:0];
                w_anode = AN_ONES;
                w_blank = 1'b0;
            end
        endcase
    end

    // Blanking only darkens segments; the anode keeps scanning so brightness stays even.
    assign w_seg = ((BLANK_LZ != 0) && w_blank) ? SEG_OFF : seg_decode(w_digit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_anode   <= AN_OFF;
            r_seg     <= SEG_OFF;
        end else begin
            r_refresh <= r_refresh + REFRESH_BITS'(1);
            r_anode   <= w_anode;
            r_seg     <= w_seg;
        end
    end

    assign bcd_valid     = w_valid;
    assign Anode         = r_anode;
    assign Seven_Seg_Out = r_seg;

endmodule
